// File: rtl/tag_pkg.sv
// tag_pkg: shared defaults and types for the rename-stage free-tag pool.
//   DEF_TAG_WIDTH  default width of one tag
//   DEF_NUM_TAGS   default pool depth (always 2**DEF_TAG_WIDTH)
//   DEF_RET_PORTS  default number of CDB return ports
//   tag_t          one tag at the default width
//   count_t        occupancy / pointer type at the default width (one wrap bit extra)
package tag_pkg;

    localparam int unsigned DEF_TAG_WIDTH = 6;
    localparam int unsigned DEF_NUM_TAGS  = 2 ** DEF_TAG_WIDTH;
    localparam int unsigned DEF_RET_PORTS = 2;

    typedef logic [DEF_TAG_WIDTH-1:0] tag_t;
    typedef logic [DEF_TAG_WIDTH:0]   count_t;

endpackage

// File: rtl/tag_ret_compact.sv
// tag_ret_compact: picks which CDB returns fit into the pool this cycle.
// Candidates (valid and kept) are accepted in ascending port order until
// 'space' is used up; each accepted port gets its write offset from wp.
//   ret_valid_i   per-port return strobe
//   keep_i        per-port keep mask (duplicate filter; all ones when unused)
//   space_i       free slots available this cycle
//   accept_c_o    ports that will be written (combinational)
//   offset_c_o    per-port offset = accepted ports below it (combinational)
//   n_accept_c_o  number of accepted ports (combinational)
module tag_ret_compact
    import tag_pkg::*;
#(
    parameter int unsigned RET_PORTS = DEF_RET_PORTS,
    parameter int unsigned CW        = DEF_TAG_WIDTH + 1
) (
    input  logic [RET_PORTS-1:0]         ret_valid_i,
    input  logic [RET_PORTS-1:0]         keep_i,
    input  logic [CW-1:0]                space_i,
    output logic [RET_PORTS-1:0]         accept_c_o,
    output logic [RET_PORTS-1:0][CW-1:0] offset_c_o,
    output logic [CW-1:0]                n_accept_c_o
);

    // Running prefix count over candidate ports.
    always_comb begin
        logic [CW-1:0] acc;
        acc          = '0;
        accept_c_o   = '0;
        offset_c_o   = '0;
        for (int j = 0; j < int'(RET_PORTS); j++) begin
            if (ret_valid_i[j] && keep_i[j]) begin
                offset_c_o[j] = acc;
                if (acc < space_i) begin
                    accept_c_o[j] = 1'b1;
                    acc           = acc + CW'(1);
                end
            end
        end
        n_accept_c_o = acc;
    end

endmodule

// File: rtl/tag_free_list.sv
// tag_free_list: free-tag pool for the rename stage. Head of the pool is the
// oldest free tag; dispatch pops it with ren, the CDB returns tags on up to
// RET_PORTS ports per cycle. Reset and flush refill tags 0..NUM_TAGS-1.
// Optional duplicate filtering is enabled by defining TAG_FREE_LIST_DUP_CHECK_EN.
//   clk, reset(async, active-low), flush(sync refill)
//   ren                 pop the head tag
//   ret_valid, ret_tag  return strobes / tags (port j at [j*TAG_WIDTH +: TAG_WIDTH])
//   tag_out             head tag (combinational from storage)
//   tag_valid, full     pool non-empty / pool full (from pointers)
//   count               free tag count (wp - rp)
//   err_underflow       pulse: ren while empty
//   err_overflow        pulse: a return was dropped for lack of space
//   err_dup             pulse: a duplicate return was dropped
module tag_free_list
    import tag_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int unsigned NUM_TAGS  = 2 ** TAG_WIDTH,
    parameter int unsigned RET_PORTS = DEF_RET_PORTS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           ren,
    input  logic [RET_PORTS-1:0]           ret_valid,
    input  logic [RET_PORTS*TAG_WIDTH-1:0] ret_tag,
    output logic [TAG_WIDTH-1:0]           tag_out,
    output logic                           tag_valid,
    output logic                           full,
    output logic [TAG_WIDTH:0]             count,
    output logic                           err_underflow,
    output logic                           err_overflow,
    output logic                           err_dup
);

    localparam int unsigned PW = TAG_WIDTH + 1;
    localparam logic [PW-1:0] WP_RESET = PW'(NUM_TAGS);

    if (NUM_TAGS != 2 ** TAG_WIDTH) begin : g_bad_depth
        $error("tag_free_list: NUM_TAGS must equal 2**TAG_WIDTH");
    end
    if (RET_PORTS == 0 || RET_PORTS > 4) begin : g_bad_ports
        $error("tag_free_list: RET_PORTS must be in 1..4");
    end

    logic [TAG_WIDTH-1:0]                storage_q [NUM_TAGS];
    logic [PW-1:0]                       rp_q, rp_d, wp_q, wp_d;
    logic                                err_uf_q, err_of_q;
    logic                                pop_c, underflow_c, overflow_c;
    logic [PW-1:0]                       space_c;
    logic [RET_PORTS-1:0][TAG_WIDTH-1:0] rtag_c;
    logic [RET_PORTS-1:0]                keep_c, accept_c;
    logic [RET_PORTS-1:0][PW-1:0]        offset_c;
    logic [PW-1:0]                       n_accept_c;
    logic [RET_PORTS-1:0][TAG_WIDTH-1:0] widx_c;

    // Status is derived from the pointers so all views agree every cycle.
    assign count     = wp_q - rp_q;
    assign tag_valid = (rp_q != wp_q);
    assign full      = (rp_q[TAG_WIDTH-1:0] == wp_q[TAG_WIDTH-1:0]) &&
                       (rp_q[TAG_WIDTH] != wp_q[TAG_WIDTH]);
    assign tag_out   = storage_q[rp_q[TAG_WIDTH-1:0]];

    assign rtag_c      = ret_tag;
    assign pop_c       = ren & tag_valid;
    assign underflow_c = ren & ~tag_valid;
    // A slot freed by this cycle's pop may be refilled in the same cycle.
    assign space_c     = PW'(NUM_TAGS) - count + PW'(pop_c);
    assign overflow_c  = |(ret_valid & keep_c & ~accept_c);

    tag_ret_compact #(
        .RET_PORTS (RET_PORTS),
        .CW        (PW)
    ) u_compact (
        .ret_valid_i  (ret_valid),
        .keep_i       (keep_c),
        .space_i      (space_c),
        .accept_c_o   (accept_c),
        .offset_c_o   (offset_c),
        .n_accept_c_o (n_accept_c)
    );

    // Pointer advance and per-port write slot.
    always_comb begin
        rp_d = rp_q + PW'(pop_c);
        wp_d = wp_q + n_accept_c;
        for (int j = 0; j < int'(RET_PORTS); j++) begin
            widx_c[j] = wp_q[TAG_WIDTH-1:0] + TAG_WIDTH'(offset_c[j]);
        end
    end

    // Storage, pointers and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_TAGS); i++) storage_q[i] <= TAG_WIDTH'(i);
            rp_q     <= '0;
            wp_q     <= WP_RESET;
            err_uf_q <= 1'b0;
            err_of_q <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < int'(NUM_TAGS); i++) storage_q[i] <= TAG_WIDTH'(i);
            rp_q     <= '0;
            wp_q     <= WP_RESET;
            err_uf_q <= 1'b0;
            err_of_q <= 1'b0;
        end else begin
            for (int j = 0; j < int'(RET_PORTS); j++) begin
                if (accept_c[j]) storage_q[widx_c[j]] <= rtag_c[j];
            end
            rp_q     <= rp_d;
            wp_q     <= wp_d;
            err_uf_q <= underflow_c;
            err_of_q <= overflow_c;
        end
    end

    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;

`ifdef TAG_FREE_LIST_DUP_CHECK_EN
    logic [NUM_TAGS-1:0] in_pool_q, in_pool_d;
    logic                dup_c, err_dup_q;

    // Drop returns already in the pool or repeated on a lower valid port.
    always_comb begin
        keep_c = '1;
        for (int j = 0; j < int'(RET_PORTS); j++) begin
            if (in_pool_q[rtag_c[j]]) keep_c[j] = 1'b0;
            for (int k = 0; k < j; k++) begin
                if (ret_valid[k] && (rtag_c[k] == rtag_c[j])) keep_c[j] = 1'b0;
            end
        end
        dup_c = |(ret_valid & ~keep_c);
    end

    // Membership tracking: clear on pop, set on accepted return.
    always_comb begin
        in_pool_d = in_pool_q;
        if (pop_c) in_pool_d[tag_out] = 1'b0;
        for (int j = 0; j < int'(RET_PORTS); j++) begin
            if (accept_c[j]) in_pool_d[rtag_c[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_pool_q <= '1;
            err_dup_q <= 1'b0;
        end else if (flush) begin
            in_pool_q <= '1;
            err_dup_q <= 1'b0;
        end else begin
            in_pool_q <= in_pool_d;
            err_dup_q <= dup_c;
        end
    end

    assign err_dup = err_dup_q;
`else
    assign keep_c  = '1;
    assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// tb_tag_free_list: directed bench for tag_free_list with a queue-based model
// of the free pool. Build with TAG_FREE_LIST_DUP_CHECK_EN to cover the
// duplicate filter.
module tb_tag_free_list;
    import tag_pkg::*;

    localparam int TW = 6;
    localparam int NT = 64;

    logic          clk = 1'b0;
    logic          reset, flush, ren;
    logic [1:0]    ret_valid;
    logic [2*TW-1:0] ret_tag;
    logic [TW-1:0] tag_out;
    logic          tag_valid, full;
    logic [TW:0]   count;
    logic          err_underflow, err_overflow, err_dup;

    tag_free_list dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .ren           (ren),
        .ret_valid     (ret_valid),
        .ret_tag       (ret_tag),
        .tag_out       (tag_out),
        .tag_valid     (tag_valid),
        .full          (full),
        .count         (count),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_dup       (err_dup)
    );

    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 1'b0;

    // Model: ordered queue of free tags, head at index 0.
    int  q[$];
    bit  exp_uf, exp_of, exp_dup;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < NT; i++) q.push_back(i);
        exp_uf  = 1'b0;
        exp_of  = 1'b0;
        exp_dup = 1'b0;
    endfunction

    function automatic bit in_q(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step(input bit fl, input bit rn, input bit [1:0] v,
                                       input int t0, input int t1);
        int tg[2];
        bit keep[2];
        bit pop;
        int space;
        if (fl) begin
            model_reset();
            return;
        end
        tg[0] = t0;
        tg[1] = t1;
        pop     = rn && (q.size() > 0);
        exp_uf  = rn && (q.size() == 0);
        exp_of  = 1'b0;
        exp_dup = 1'b0;
        for (int j = 0; j < 2; j++) begin
            keep[j] = 1'b1;
`ifdef TAG_FREE_LIST_DUP_CHECK_EN
            if (v[j]) begin
                if (in_q(tg[j])) keep[j] = 1'b0;
                if (j == 1 && v[0] && t0 == t1) keep[j] = 1'b0;
                if (!keep[j]) exp_dup = 1'b1;
            end
`endif
        end
        space = NT - q.size() + int'(pop);
        if (pop) void'(q.pop_front());
        for (int j = 0; j < 2; j++) begin
            if (v[j] && keep[j]) begin
                if (space > 0) begin
                    q.push_back(tg[j]);
                    space--;
                end else begin
                    exp_of = 1'b1;
                end
            end
        end
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 32'(count), 32'(q.size()));
            check("full", 32'(full), 32'(q.size() == NT));
            check("tag_valid", 32'(tag_valid), 32'(q.size() != 0));
            if (q.size() != 0) check("tag_out", 32'(tag_out), 32'(q[0]));
            check("err_underflow", 32'(err_underflow), 32'(exp_uf));
            check("err_overflow", 32'(err_overflow), 32'(exp_of));
            check("err_dup", 32'(err_dup), 32'(exp_dup));
        end
    end

    task automatic step(input bit fl, input bit rn, input bit [1:0] v, input int t0, input int t1);
        flush     = fl;
        ren       = rn;
        ret_valid = v;
        ret_tag   = {TW'(t1), TW'(t0)};
        model_step(fl, rn, v, t0, t1);
        @(posedge clk);
        @(negedge clk);
        #1;
        flush     = 1'b0;
        ren       = 1'b0;
        ret_valid = 2'b00;
    endtask

    int popped[$];

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        ren       = 1'b0;
        ret_valid = 2'b00;
        ret_tag   = '0;
        model_reset();
        chk_en    = 1'b1;
        @(negedge clk);
        #1;
        check("lit_reset_count", 32'(count), 32'd64);
        reset = 1'b1;

        // Reset release, then three pops.
        step(0, 0, 2'b00, 0, 0);
        check("lit_idle_tag_out", 32'(tag_out), 32'd0);
        check("lit_idle_count", 32'(count), 32'd64);
        check("lit_idle_full", 32'(full), 32'd1);
        check("lit_idle_valid", 32'(tag_valid), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 2'b00, 0, 0);
            check("lit_pop_tag_out", 32'(tag_out), 32'(i));
        end
        check("lit_pop3_count", 32'(count), 32'd61);

        // Drain, then underflow.
        for (int i = 0; i < 61; i++) step(0, 1, 2'b00, 0, 0);
        check("lit_empty_valid", 32'(tag_valid), 32'd0);
        check("lit_empty_count", 32'(count), 32'd0);
        step(0, 1, 2'b00, 0, 0);
        check("lit_underflow", 32'(err_underflow), 32'd1);
        check("lit_underflow_count", 32'(count), 32'd0);
        step(0, 0, 2'b00, 0, 0);
        check("lit_underflow_clear", 32'(err_underflow), 32'd0);

        // Return two tags into the empty pool.
        step(0, 0, 2'b11, 9, 4);
        check("lit_ret_count", 32'(count), 32'd2);
        check("lit_ret_head", 32'(tag_out), 32'd9);
        step(0, 1, 2'b00, 0, 0);
        check("lit_ret_next", 32'(tag_out), 32'd4);
        step(0, 1, 2'b00, 0, 0);
        // Empty pool with pop and return together: no bypass.
        step(0, 1, 2'b01, 17, 0);
        check("lit_nobypass_uf", 32'(err_underflow), 32'd1);
        check("lit_nobypass_head", 32'(tag_out), 32'd17);

        // Full pool: pop plus two returns, one fits.
        step(1, 0, 2'b00, 0, 0);
        step(0, 1, 2'b11, 5, 7);
`ifndef TAG_FREE_LIST_DUP_CHECK_EN
        check("lit_overflow", 32'(err_overflow), 32'd1);
        check("lit_overflow_count", 32'(count), 32'd64);
`endif

        // Pop 60 and return them, twice, so the write pointer wraps.
        step(1, 0, 2'b00, 0, 0);
        for (int r = 0; r < 2; r++) begin
            popped.delete();
            for (int i = 0; i < 60; i++) begin
                popped.push_back(q[0]);
                step(0, 1, 2'b00, 0, 0);
            end
            check("lit_wrap_low", 32'(count), 32'd4);
            for (int k = 0; k < 60; k += 2) step(0, 0, 2'b11, popped[k], popped[k+1]);
            check("lit_wrap_count", 32'(count), 32'd64);
        end
        // Flush wins over ren and a return.
        step(1, 1, 2'b01, 33, 0);
        check("lit_flush_count", 32'(count), 32'd64);
        check("lit_flush_head", 32'(tag_out), 32'd0);
        check("lit_flush_uf", 32'(err_underflow), 32'd0);
        check("lit_flush_of", 32'(err_overflow), 32'd0);

`ifdef TAG_FREE_LIST_DUP_CHECK_EN
        step(0, 1, 2'b00, 0, 0);
        step(0, 0, 2'b11, 0, 0);
        check("lit_dup_same", 32'(err_dup), 32'd1);
        check("lit_dup_count", 32'(count), 32'd64);
        step(0, 0, 2'b01, 3, 0);
        check("lit_dup_inpool", 32'(err_dup), 32'd1);
        check("lit_dup_no_of", 32'(err_overflow), 32'd0);
        check("lit_dup_count2", 32'(count), 32'd64);
`endif

        // Mixed traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            bit [1:0] v;
            v = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step((i % 97) == 96, 1'($urandom_range(0, 1)), v,
                 int'($urandom_range(0, NT-1)), int'($urandom_range(0, NT-1)));
        end

        // Asynchronous reset mid-cycle drops the pending pop and returns.
        for (int i = 0; i < 10; i++) step(0, 1, 2'b00, 0, 0);
        ren       = 1'b1;
        ret_valid = 2'b11;
        ret_tag   = {TW'(2), TW'(1)};
        #2;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        ren       = 1'b0;
        ret_valid = 2'b00;
        reset     = 1'b1;
        check("lit_async_count", 32'(count), 32'd64);
        check("lit_async_head", 32'(tag_out), 32'd0);
        step(0, 1, 2'b00, 0, 0);
        check("lit_async_pop", 32'(tag_out), 32'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
